// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer, empty/almost-empty flags and occupancy for an async FIFO
module fifo_rd_ctrl #(
  parameter int address_Size = 5,
  parameter int ae_Thresh = 4
) (
  input  logic                    r_Clk,
  input  logic                    r_Rst,
  input  logic                    r_Inc,
  input  logic [address_Size:0]   w_Ptr,
  output logic [address_Size-1:0] r_Addr,
  output logic [address_Size:0]   r_Ptr,
  output logic                    fifo_Empty,
  output logic                    almost_Empty,
  output logic [address_Size:0]   r_Count
);
  localparam logic [address_Size:0] AE = (address_Size+1)'(ae_Thresh);
  logic [address_Size:0] rsync_q1, rsync_Wptr, r_Bin, r_NextBin, r_NextGray, wsync_Bin, r_Diff;
  // Gray to binary: each bit is the XOR of all gray bits at or above it
  for (genvar i = 0; i <= address_Size; i++) begin : g_g2b
    assign wsync_Bin[i] = ^rsync_Wptr[address_Size:i];
  end
  assign r_NextBin  = r_Bin + {{address_Size{1'b0}}, r_Inc & ~fifo_Empty};
  assign r_NextGray = (r_NextBin >> 1) ^ r_NextBin;
  assign r_Diff     = wsync_Bin - r_NextBin;
  assign r_Addr     = r_Bin[address_Size-1:0];
  always_ff @(posedge r_Clk or negedge r_Rst)
    if (!r_Rst) begin
      rsync_q1     <= '0;
      rsync_Wptr   <= '0;
      r_Bin        <= '0;
      r_Ptr        <= '0;
      r_Count      <= '0;
      fifo_Empty   <= 1'b1;
      almost_Empty <= 1'b1;
    end else begin
      rsync_q1     <= w_Ptr;
      rsync_Wptr   <= rsync_q1;
      r_Bin        <= r_NextBin;
      r_Ptr        <= r_NextGray;
      r_Count      <= r_Diff;
      fifo_Empty   <= r_NextGray == rsync_Wptr;
      almost_Empty <= r_Diff <= AE;
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: random and directed checks of fifo_rd_ctrl against an occupancy model
module tb_fifo_rd_ctrl;
  logic       r_Clk = 0;
  logic       r_Rst = 0;
  logic       r_Inc = 0;
  logic [5:0] w_Ptr = 0;
  logic [4:0] r_Addr;
  logic [5:0] r_Ptr;
  logic       fifo_Empty, almost_Empty;
  logic [5:0] r_Count;
  int checks = 0, failures = 0;
  int wcnt = 0;
  int m_rd = 0, m_s1 = 0, m_s2 = 0, m_occ = 0;
  bit m_empty = 1;

  fifo_rd_ctrl #(.address_Size(5), .ae_Thresh(4)) dut (
    .r_Clk(r_Clk), .r_Rst(r_Rst), .r_Inc(r_Inc), .w_Ptr(w_Ptr),
    .r_Addr(r_Addr), .r_Ptr(r_Ptr), .fifo_Empty(fifo_Empty),
    .almost_Empty(almost_Empty), .r_Count(r_Count)
  );

  always #5 r_Clk = ~r_Clk;

  function automatic int gray(int x);
    return (x ^ (x >> 1)) & 63;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy model: the read side sees the write count two edges late
  always @(posedge r_Clk or negedge r_Rst)
    if (!r_Rst) begin
      m_rd = 0; m_s1 = 0; m_s2 = 0; m_occ = 0; m_empty = 1;
    end else begin
      if (r_Inc && !m_empty) m_rd = (m_rd + 1) & 63;
      m_occ = (m_s2 - m_rd) & 63;
      m_empty = (m_occ == 0);
      m_s2 = m_s1;
      m_s1 = wcnt & 63;
    end

  always @(negedge r_Clk) begin
    chk("m_addr", r_Addr, m_rd & 31);
    chk("m_ptr", r_Ptr, gray(m_rd));
    chk("m_empty", fifo_Empty, m_empty);
    chk("m_ae", almost_Empty, m_occ <= 4);
    chk("m_count", r_Count, m_occ);
  end

  task automatic step();
    @(posedge r_Clk);
    #1;
  endtask

  task automatic drive_w(int n);
    wcnt = n;
    w_Ptr = 6'(gray(n & 63));
  endtask

  task automatic do_reset();
    r_Rst = 0; r_Inc = 0; drive_w(0);
    step(); step();
    r_Rst = 1;
    step();
  endtask

  initial begin
    step(); step();
    chk("rst_addr", r_Addr, 0);
    chk("rst_ptr", r_Ptr, 0);
    chk("rst_empty", fifo_Empty, 1);
    chk("rst_ae", almost_Empty, 1);
    chk("rst_count", r_Count, 0);
    r_Rst = 1;
    step();
    drive_w(3);
    step(); chk("fill1_empty", fifo_Empty, 1);
    step(); chk("fill2_empty", fifo_Empty, 1);
    step();
    chk("fill3_empty", fifo_Empty, 0);
    chk("fill3_count", r_Count, 3);
    chk("fill3_ae", almost_Empty, 1);
    r_Inc = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("drain_addr", r_Addr, i);
      chk("drain_count", r_Count, 3 - i);
      chk("drain_empty", fifo_Empty, i == 3);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("uf_addr", r_Addr, 3);
      chk("uf_ptr", r_Ptr, 6'b000010);
      chk("uf_count", r_Count, 0);
      chk("uf_empty", fifo_Empty, 1);
    end
    r_Inc = 0;
    do_reset();
    drive_w(6);
    step(); step(); step();
    chk("fill6_count", r_Count, 6);
    chk("fill6_ae", almost_Empty, 0);
    chk("fill6_empty", fifo_Empty, 0);
    r_Inc = 1; step(); r_Inc = 0; step();
    chk("pre_rst_count", r_Count, 5);
    #2 r_Rst = 0;
    #1;
    chk("mid_rst_addr", r_Addr, 0);
    chk("mid_rst_ptr", r_Ptr, 0);
    chk("mid_rst_empty", fifo_Empty, 1);
    chk("mid_rst_ae", almost_Empty, 1);
    chk("mid_rst_count", r_Count, 0);
    do_reset();
    drive_w(33);
    step(); step(); step();
    chk("wrap_count", r_Count, 33);
    r_Inc = 1;
    for (int i = 1; i <= 33; i++) begin
      step();
      chk("wrap_addr", r_Addr, i % 32);
      chk("wrap_empty", fifo_Empty, i == 33);
      if (i == 32) chk("wrap_ptr32", r_Ptr, 6'b110000);
    end
    r_Inc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
      end
      if (((wcnt - m_rd) & 63) < 32 && $urandom_range(0, 1) == 1) drive_w((wcnt + 1) & 63);
      r_Inc = ($urandom_range(0, 2) != 0);
      step();
    end
    r_Inc = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
